// File: rtl/sr_arb_pkg.sv
// Shared types and op encodings for the SR flag arbiter.
package sr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_e;

  // {S,R} encodings
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

endpackage

// File: rtl/sr_flag_bank.sv
// Bank of clocked SR flag cells; S=R=1 resolves to Q=0.
module sr_flag_bank
  import sr_arb_pkg::*;
#(
  parameter int NUM_FLAGS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FLAGS-1:0] s,
  input  logic [NUM_FLAGS-1:0] r,
  output logic [NUM_FLAGS-1:0] q
);

  // per-cell SR update
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < NUM_FLAGS; i++) begin
        case ({s[i], r[i]})
          OP_SET:  q[i] <= 1'b1;
          OP_CLR:  q[i] <= 1'b0;
          OP_ILL:  q[i] <= 1'b0;
          default: q[i] <= q[i];
        endcase
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Arbitrates set/clear requests onto an SR flag bank via IDLE/APPLY/ACK.
// Define SR_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module sr_flag_arbiter
  import sr_arb_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  NUM_FLAGS = 8,
  localparam int IDX_W     = $clog2(NUM_FLAGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [IDX_W*NUM_REQ-1:0] req_idx,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_FLAGS-1:0]     flags,
  output logic                     busy,
  output logic                     err
);

  localparam int RW = $clog2(NUM_REQ);

  state_e               state_r;
  logic [RW-1:0]        win_id_r;
  logic [1:0]           win_op_r;
  logic [IDX_W-1:0]     win_idx_r;
  logic [NUM_REQ-1:0]   gnt_r;
  logic                 err_r;
  logic                 busy_r;
  logic [RW-1:0]        start_s;
  logic [RW-1:0]        pick_s;
  logic                 found_s;
  logic                 oor_s;
  logic [NUM_FLAGS-1:0] s_s;
  logic [NUM_FLAGS-1:0] r_s;
  logic [1:0]           op_a  [NUM_REQ];
  logic [IDX_W-1:0]     idx_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_a[g]  = req_op[2*g +: 2];
    assign idx_a[g] = req_idx[IDX_W*g +: IDX_W];
  end

`ifdef SR_ARB_FIXED_PRIO_EN
  assign start_s = '0;
`else
  logic [RW-1:0] rr_ptr_r;
  assign start_s = rr_ptr_r;

  // advance the round-robin pointer past the requester just served
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (state_r == ACK) begin
      rr_ptr_r <= (win_id_r == RW'(NUM_REQ - 1)) ? '0 : win_id_r + RW'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

  // first requesting index at or after start_s, wrapping
  always_comb begin
    int cand_v;
    found_s = 1'b0;
    pick_s  = '0;
    cand_v  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_v = int'(start_s) + i;
      if (cand_v >= NUM_REQ) begin
        cand_v = cand_v - NUM_REQ;
      end else begin
        cand_v = cand_v;
      end
      if (!found_s && req[cand_v[RW-1:0]]) begin
        found_s = 1'b1;
        pick_s  = cand_v[RW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign oor_s = (int'(win_idx_r) >= NUM_FLAGS);

  // only the addressed cell sees the op, and only in APPLY
  always_comb begin
    s_s = '0;
    r_s = '0;
    if ((state_r == APPLY) && !oor_s) begin
      s_s[win_idx_r] = win_op_r[1];
      r_s[win_idx_r] = win_op_r[0];
    end else begin
      s_s = '0;
      r_s = '0;
    end
  end

  // sequencing FSM with registered gnt/err/busy
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      win_id_r  <= '0;
      win_op_r  <= OP_NOP;
      win_idx_r <= '0;
      gnt_r     <= '0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          gnt_r <= '0;
          err_r <= 1'b0;
          if (found_s) begin
            win_id_r  <= pick_s;
            win_op_r  <= op_a[pick_s];
            win_idx_r <= idx_a[pick_s];
            busy_r    <= 1'b1;
            state_r   <= APPLY;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        APPLY: begin
          gnt_r   <= NUM_REQ'(1) << win_id_r;
          err_r   <= (win_op_r == OP_ILL) || oor_s;
          busy_r  <= 1'b1;
          state_r <= ACK;
        end
        ACK: begin
          gnt_r   <= '0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          gnt_r   <= '0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  sr_flag_bank #(
    .NUM_FLAGS(NUM_FLAGS)
  ) u_bank (
    .clk(clk),
    .rst(rst),
    .s  (s_s),
    .r  (r_s),
    .q  (flags)
  );

  assign gnt  = gnt_r;
  assign err  = err_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter (NUM_REQ=4, NUM_FLAGS=6 so index 7 is out of range).
module tb_sr_flag_arbiter;

  localparam int NR = 4;
  localparam int NF = 6;
  localparam int IW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [2*NR-1:0]  req_op;
  logic [IW*NR-1:0] req_idx;
  logic [NR-1:0]    gnt;
  logic [NF-1:0]    flags;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_flag_arbiter #(
    .NUM_REQ  (NR),
    .NUM_FLAGS(NF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .req_op (req_op),
    .req_idx(req_idx),
    .gnt    (gnt),
    .flags  (flags),
    .busy   (busy),
    .err    (err)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [2:0] idx);
    req[r]            = 1'b1;
    req_op[2*r +: 2]  = op;
    req_idx[IW*r +: IW] = idx;
  endtask

  // single request issued from IDLE, checked through APPLY, ACK and back to IDLE
  task automatic do_op(input int r, input logic [1:0] op, input logic [2:0] idx,
                       input logic [NF-1:0] exp_flags, input logic exp_err, input string tag);
    logic [NR-1:0] exp_gnt;
    exp_gnt = '0;
    exp_gnt[r] = 1'b1;
    set_req(r, op, idx);
    cyc;
    chk({tag, "_apply_busy"}, 32'(busy), 32'd1);
    chk({tag, "_apply_gnt"}, 32'(gnt), 32'd0);
    cyc;
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, "_flags"}, 32'(flags), 32'(exp_flags));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    req[r] = 1'b0;
    cyc;
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [NR-1:0] exp_g;
    rst     = 1'b1;
    req     = '0;
    req_op  = '0;
    req_idx = '0;
    cyc;
    cyc;
    rst = 1'b0;
    cyc;
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // all four request at once, each held until its grant
    for (int i = 0; i < NR; i++) set_req(i, 2'b10, 3'(i));
    for (int k = 0; k < NR; k++) begin
      cyc;
      chk("rr_busy", 32'(busy), 32'd1);
      cyc;
      exp_g = '0;
      exp_g[k] = 1'b1;
      chk("rr_gnt", 32'(gnt), 32'(exp_g));
      chk("rr_err", 32'(err), 32'd0);
      req[k] = 1'b0;
      cyc;
      chk("rr_idle_gnt", 32'(gnt), 32'd0);
    end
    chk("rr_flags", 32'(flags), 32'h0f);

    // requesters 0 and 1 held high continuously, no-op ops
    set_req(0, 2'b00, 3'd0);
    set_req(1, 2'b00, 3'd1);
    for (int k = 0; k < 4; k++) begin
      cyc;
      cyc;
`ifdef SR_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
      chk("prio_gnt", 32'(gnt), 32'(exp_g));
      cyc;
    end
    req = '0;
    chk("nop_flags", 32'(flags), 32'h0f);

    rst = 1'b1;
    cyc;
    rst = 1'b0;
    chk("rst2_flags", 32'(flags), 32'd0);

    // single set, step by step
    set_req(0, 2'b10, 3'd3);
    chk("set_n_busy", 32'(busy), 32'd0);
    cyc;
    chk("set_n1_busy", 32'(busy), 32'd1);
    chk("set_n1_gnt", 32'(gnt), 32'd0);
    chk("set_n1_flags", 32'(flags), 32'd0);
    cyc;
    chk("set_n2_flags", 32'(flags), 32'h08);
    chk("set_n2_gnt", 32'(gnt), 32'h1);
    chk("set_n2_busy", 32'(busy), 32'd1);
    chk("set_n2_err", 32'(err), 32'd0);
    req[0] = 1'b0;
    cyc;
    chk("set_n3_busy", 32'(busy), 32'd0);
    chk("set_n3_gnt", 32'(gnt), 32'd0);

    do_op(2, 2'b10, 3'd5, 6'b101000, 1'b0, "set5");
    do_op(2, 2'b11, 3'd5, 6'b001000, 1'b1, "ill5");
    do_op(3, 2'b10, 3'd7, 6'b001000, 1'b1, "oor7");
    do_op(1, 2'b01, 3'd3, 6'b000000, 1'b0, "clr3");
    do_op(1, 2'b10, 3'd4, 6'b010000, 1'b0, "set4");

    // reset lands during APPLY
    set_req(0, 2'b10, 3'd2);
    cyc;
    chk("mid_apply_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    req = '0;
    cyc;
    chk("mid_flags", 32'(flags), 32'd0);
    chk("mid_gnt", 32'(gnt), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cyc;
    chk("post_gnt", 32'(gnt), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_flags", 32'(flags), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
Shares a bank of NUM_FLAGS SR flag cells among NUM_REQ requesters. Each requester asks to set or clear one indexed flag. A round-robin arbiter picks one request at a time and sequences it through a 3-state FSM. It drives the S/R inputs of the selected cell and returns a one-cycle grant. The block sits between software-visible status/control logic and the SR flag storage, and owns all flag writes.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_FLAGS, 8, number of SR flag cells (2..32)
IDX_W, $clog2(NUM_FLAGS), flag index width (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request, level; held until gnt
req_op  in  2*NUM_REQ  per-requester {S,R}: 10 set, 01 clear, 00 no-op, 11 illegal
req_idx  in  IDX_W*NUM_REQ  per-requester target flag index
gnt  out  NUM_REQ  one-hot, one-cycle completion pulse
flags  out  NUM_FLAGS  current Q of every flag cell
busy  out  1  high while FSM not IDLE
err  out  1  one-cycle pulse with gnt when op was 11 or idx >= NUM_FLAGS

Behaviour:
- Reset (synchronous, active-high, overrides all other activity, including mid-operation): state=IDLE, flags=0, gnt=0, busy=0, err=0, rr_ptr=0. No grant is issued for an operation interrupted by reset.
- FSM states: IDLE, APPLY, ACK.
- IDLE: if any req is high, pick the winner by round-robin starting at rr_ptr. Register win_id, win_op, win_idx, then go to APPLY. If no req is high, stay in IDLE.
- APPLY: drive {S,R}=win_op to cell win_idx and {0,0} to all other cells. The cell updates on this clock edge. Go to ACK.
- ACK: gnt[win_id]=1 for exactly this cycle. flags already shows the new value. rr_ptr=(win_id+1) mod NUM_REQ. Return to IDLE.
- Latency: req sampled in cycle N, flag change visible in N+2, gnt in N+2. Throughput is one operation per 3 cycles.
- Op 10 sets Q=1. Op 01 sets Q=0. Op 00 holds Q but still completes with gnt.
- Op 11: Q forced to 0 (cell's defined 11 behaviour), gnt issued, err=1.
- idx >= NUM_FLAGS: no cell is written, gnt issued, err=1.
- Requests are captured only in IDLE. A req dropped before capture is ignored. A req dropped after capture still completes.
- A req still high in the cycle after its gnt counts as a new request.
- busy=1 in APPLY and ACK.
- Only one flag changes per operation. Flags not addressed never change.

Optional Feature:
Macro SR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest requester index wins. rr_ptr is not implemented.
- Undefined (default): round-robin as described above.
- Timing and all other behaviour are identical in both builds.

Decomposition:
- Package sr_arb_pkg holds:
  - state enum {IDLE, APPLY, ACK}
  - op constants OP_NOP=00, OP_CLR=01, OP_SET=10, OP_ILL=11
- Sub-module sr_flag_bank: NUM_FLAGS clocked SR cells with synchronous active-high reset, taking per-cell S/R vectors and producing flags.
- The arbiter and FSM live in sr_flag_arbiter.

Test Plan:
- Reset check: rst=1 for 2 cycles, then 0 -> flags=0, gnt=0, busy=0, state IDLE.
- Single set: req[0]=1, op=10, idx=3 at cycle N -> flags[3]=1 at N+2, gnt=0001 at N+2, busy=1 for N+1..N+2, req[0] dropped at N+3.
- Round-robin: req=1111 all op=10, idx=0,1,2,3, each held until its gnt -> grants in order 0,1,2,3, 3 cycles apart; flags[3:0]=1111. Repeat with SR_ARB_FIXED_PRIO_EN and only req 0/1 high, re-asserted after each gnt -> requester 1 is starved.
- Illegal op and out-of-range index: flags[5]=1, then req[2] op=11 idx=5 -> flags[5]=0, gnt[2] and err pulse together. With NUM_FLAGS=6 and idx=7 -> no flag changes, err=1.
- Reset mid-op: assert rst during APPLY -> next cycle flags=0, no gnt, state IDLE.
